decoder_2_4: RTL and testbench

//   2-to-4 line decoder with enable and registered outputs. Input pair {a,b} selects one of four
//   one-hot outputs y0..y3; en gates all outputs. Used as a small address/select decoder in

---
 rtl/decoder_2_4.sv | 76 +++++++
 tb/tb_decoder_2_4.sv | 139 +++++++++++++
 2 files changed

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder with enable, optional output register and pin inversion.
// Optional one-hot checker and select counter enabled by DECODER_2_4_ONEHOT_CHK_EN.
module decoder_2_4 #(
  parameter bit OUT_REG    = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       en,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       active
`ifdef DECODER_2_4_ONEHOT_CHK_EN
  ,
  output logic       onehot_err,
  output logic [7:0] sel_cnt
`endif
);

  logic [3:0] dec_p0;
  logic [3:0] dec_p1;
  logic [3:0] y_vec;
  logic       act;

  function automatic logic [3:0] decode(input logic sel_a, input logic sel_b,
                                        input logic sel_en);
    logic [3:0] v;
    v = 4'b0000;
    if (sel_en)
      v[{sel_a, sel_b}] = 1'b1;
    return v;
  endfunction

  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'b0000;
  endfunction

  // stage p0: combinational decode of the live inputs
  always_comb begin
    dec_p0 = decode(a, b, en);
  end

  // stage p1: registered decode
  always_ff @(posedge clk) begin
    if (!rst_n)
      dec_p1 <= 4'b0000;
    else
      dec_p1 <= dec_p0;
  end

  // Combinational mode still honours reset by forcing the lines low while rst_n is low.
  assign y_vec = OUT_REG ? dec_p1 : (rst_n ? dec_p0 : 4'b0000);
  assign act   = |y_vec;

  assign {y3, y2, y1, y0} = ACTIVE_LOW ? ~y_vec : y_vec;
  assign active           = ACTIVE_LOW ? ~act   : act;

`ifdef DECODER_2_4_ONEHOT_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
      sel_cnt    <= 8'd0;
    end else begin
      if (multi_hot(dec_p1))
        onehot_err <= 1'b1;
      if (act)
        sel_cnt <= sel_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_2_4.sv
// Randomised self-checking bench for decoder_2_4: registered, combinational and inverted builds.
// Exercises the one-hot checker and counter when DECODER_2_4_ONEHOT_CHK_EN is defined.
`timescale 1ns/1ps
module tb_decoder_2_4;

  logic clk = 1'b0;
  logic rst_n, a, b, en;
  logic r_y0, r_y1, r_y2, r_y3, r_act;
  logic c_y0, c_y1, c_y2, c_y3, c_act;
  logic l_y0, l_y1, l_y2, l_y3, l_act;
`ifdef DECODER_2_4_ONEHOT_CHK_EN
  logic       r_err, c_err, l_err;
  logic [7:0] r_cnt, c_cnt, l_cnt;
  int         m_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] m_reg;

  always #5 clk = ~clk;

  decoder_2_4 #(.OUT_REG(1'b1), .ACTIVE_LOW(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
    .y0(r_y0), .y1(r_y1), .y2(r_y2), .y3(r_y3), .active(r_act)
`ifdef DECODER_2_4_ONEHOT_CHK_EN
    , .onehot_err(r_err), .sel_cnt(r_cnt)
`endif
  );

  decoder_2_4 #(.OUT_REG(1'b0), .ACTIVE_LOW(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
    .y0(c_y0), .y1(c_y1), .y2(c_y2), .y3(c_y3), .active(c_act)
`ifdef DECODER_2_4_ONEHOT_CHK_EN
    , .onehot_err(c_err), .sel_cnt(c_cnt)
`endif
  );

  decoder_2_4 #(.OUT_REG(1'b1), .ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
    .y0(l_y0), .y1(l_y1), .y2(l_y2), .y3(l_y3), .active(l_act)
`ifdef DECODER_2_4_ONEHOT_CHK_EN
    , .onehot_err(l_err), .sel_cnt(l_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference: the selected line is numbered 2*a+b and carries en.
  function automatic logic [3:0] ref_dec(input logic ra, input logic rb, input logic ren);
    int idx;
    idx = 2 * int'(ra) + int'(rb);
    return ren ? 4'(1 << idx) : 4'd0;
  endfunction

  // Called at a falling edge: drive, check combinational build, let one rising edge pass,
  // then check the registered builds at the next falling edge.
  task automatic step(input logic ra, input logic rb, input logic ren, input logic rrst_n);
    logic [3:0] comb_exp;
    rst_n = rrst_n; a = ra; b = rb; en = ren;
    #1;
    comb_exp = rrst_n ? ref_dec(ra, rb, ren) : 4'd0;
    check("comb", {27'd0, c_act, c_y3, c_y2, c_y1, c_y0}, {27'd0, comb_exp != 4'd0, comb_exp});
`ifdef DECODER_2_4_ONEHOT_CHK_EN
    if (!rrst_n)
      m_cnt = 0;
    else if (m_reg != 4'd0)
      m_cnt = (m_cnt + 1) % 256;
`endif
    m_reg = rrst_n ? ref_dec(ra, rb, ren) : 4'd0;
    @(negedge clk);
    check("reg", {27'd0, r_act, r_y3, r_y2, r_y1, r_y0}, {27'd0, m_reg != 4'd0, m_reg});
    check("al",  {27'd0, l_act, l_y3, l_y2, l_y1, l_y0}, {27'd0, ~(m_reg != 4'd0), ~m_reg});
`ifdef DECODER_2_4_ONEHOT_CHK_EN
    check("cnt", {24'd0, r_cnt}, m_cnt);
    check("err", {31'd0, r_err | l_err | c_err}, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; a = 1'b0; b = 1'b0; en = 1'b0;
    m_reg = 4'd0;
`ifdef DECODER_2_4_ONEHOT_CHK_EN
    m_cnt = 0;
`endif
    @(negedge clk);
    // reset with enabled inputs present: reset must win
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // full truth-table sweep over {a,b,en}
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(v[2], v[1], v[0], 1'b1);
    end

    // enable low: every select value decodes to nothing
    for (int i = 0; i < 4; i++) begin
      logic [1:0] s;
      s = 2'(i);
      step(s[1], s[0], 1'b0, 1'b1);
    end

    // reset in the middle of a steady a=b=en=1
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);

    // random traffic with occasional reset
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 15) != 0));

`ifdef DECODER_2_4_ONEHOT_CHK_EN
    // counter wrap: active for 260 counted cycles lands on 4
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 261; i++)
      step(1'($urandom), 1'($urandom), 1'b1, 1'b1);
    check("wrap", {24'd0, r_cnt}, 32'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
